// File: rtl/mult_seq_pkg.sv
// Shared constants and helpers for the sequential multiply/divide units.
package mult_seq_pkg;

  localparam int unsigned MUL_N  = 32;
  localparam int unsigned MUL_CW = 5;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_op_t;

  typedef enum logic {
    StIdle,
    StRun
  } mul_state_t;

  // Two's-complement negate when c is set; turns a signed operand into its magnitude.
  function automatic logic [MUL_N-1:0] neg_if(input logic [MUL_N-1:0] x, input logic c);
    return c ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy handshake and result bus shared by the sequential multiplier and its controller.
interface mult_seq_if import mult_seq_pkg::*; #(
  parameter int unsigned N = MUL_N
) ();

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sign;
  logic         start;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         busy;
  logic         done;

  modport master (
    output a, b, sign, start,
    input  hi, lo, busy, done
  );

  modport slave (
    input  a, b, sign, start,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_seq.sv
// Iterative NxN -> 2N shift-add multiplier (MULT/MULTU) with start/busy/done handshake.
// Define MULT_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_seq import mult_seq_pkg::*; #(
  parameter int unsigned N  = MUL_N,
  parameter int unsigned CW = MUL_CW
) (
  input logic       clock,
  input logic       reset,
  mult_seq_if.slave bus
);

  mul_state_t     state_q;
  logic [N-1:0]   reg_a_q;
  logic [N-1:0]   reg_b_q;
  logic [N:0]     acc_hi_q;
  logic [CW-1:0]  count_q;
  logic           neg_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic           done_q;

  logic           op_signed;
  logic [N:0]     sum;
  logic [2*N-1:0] prod_full;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_signed;
  logic           last_iter;
  logic           finish;

  assign op_signed = (mul_op_t'(bus.sign) == MUL_SIGNED);
  assign sum       = acc_hi_q + (reg_b_q[0] ? {1'b0, reg_a_q} : '0);
  // Product after this edge's add and shift: the new acc_hi sits above the shifted reg_b.
  assign prod_full = {sum, reg_b_q[N-1:1]};
  assign last_iter = (count_q == CW'(N - 1));

`ifdef MULT_EARLY_OUT_EN
  logic [N-1:0]   rem_mask;
  logic           early;
  logic [CW:0]    shamt;
  logic [2*N-1:0] prod_early;

  assign rem_mask   = {N{1'b1}} >> count_q;
  assign early      = ((reg_b_q & rem_mask) == '0);
  assign shamt      = (CW + 1)'(N) - {1'b0, count_q};
  // No further adds remain, so the outstanding shifts collapse into one.
  assign prod_early = {acc_hi_q[N-1:0], reg_b_q} >> shamt;
  assign finish     = last_iter | early;
  assign prod       = early ? prod_early : prod_full;
`else
  assign finish     = last_iter;
  assign prod       = prod_full;
`endif

  assign prod_signed = neg_q ? (~prod + 1'b1) : prod;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      acc_hi_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            reg_a_q  <= neg_if(bus.a, op_signed & bus.a[N-1]);
            reg_b_q  <= neg_if(bus.b, op_signed & bus.b[N-1]);
            neg_q    <= op_signed & (bus.a[N-1] ^ bus.b[N-1]);
            acc_hi_q <= '0;
            count_q  <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_hi_q <= {1'b0, sum[N:1]};
          reg_b_q  <= {sum[0], reg_b_q[N-1:1]};
          count_q  <= count_q + 1'b1;
          if (finish) begin
            {hi_q, lo_q} <= prod_signed;
            done_q       <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: driver queues reference products, a monitor checks each done.
module tb_mult_seq;
  import mult_seq_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned acc;
    int unsigned due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exp_t        sb[$];
  int unsigned cycle    = 0;
  int unsigned idle_at  = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  mult_seq_if #(.N(MUL_N)) bus ();

  mult_seq #(.N(MUL_N), .CW(MUL_CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    longint sx, sy;
    sx = s ? longint'($signed(x)) : longint'({32'h0, x});
    sy = s ? longint'($signed(y)) : longint'({32'h0, y});
    return 64'(sx * sy);
  endfunction

  function automatic int unsigned ref_lat(input logic [31:0] y, input logic s);
`ifdef MULT_EARLY_OUT_EN
    logic [31:0] m;
    int unsigned bl;
    m  = (s && y[31]) ? (32'h0 - y) : y;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    return (bl + 1 > 32) ? 32 : bl + 1;
`else
    return (s && y[31]) ? 32 : 32;
`endif
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    logic [63:0] p;
    @(negedge clock);
    while (cycle < idle_at) @(negedge clock);
    bus.a     = x;
    bus.b     = y;
    bus.sign  = s;
    bus.start = 1'b1;
    p     = ref_prod(x, y, s);
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.acc = cycle + 1;
    e.due = cycle + 1 + ref_lat(y, s);
    sb.push_back(e);
    idle_at = e.due;
    @(negedge clock);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sign  = 1'($urandom);
  endtask

  // Monitor: pops the scoreboard on done, otherwise checks hold/busy and overdue results.
  initial begin
    exp_t e;
    logic busy_exp;
    forever begin
      @(posedge clock);
      #1;
      if (reset) continue;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("hi", 64'(bus.hi), 64'(e.hi));
          check("lo", 64'(bus.lo), 64'(e.lo));
          check("done_cycle", 64'(cycle), 64'(e.due));
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end else begin
        check("hold", {bus.hi, bus.lo}, {last_hi, last_lo});
        if (sb.size() > 0 && cycle > sb[0].due) begin
          check("done_missing", 64'(bus.done), 64'd1);
          void'(sb.pop_front());
        end
      end
      busy_exp = (sb.size() > 0) && (cycle >= sb[0].acc) && (cycle < sb[0].due);
      check("busy", 64'(bus.busy), 64'(busy_exp));
    end
  end

  initial begin
    logic [31:0] x, y;
    logic s;
    bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.start = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Directed corners, issued back-to-back in each done cycle.
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(32'hFFFFFFFD, 32'd5, 1'b1);
    issue(32'hFFFFFFFD, 32'd5, 1'b0);
    issue(32'h80000000, 32'h80000000, 1'b1);
    issue(32'h80000000, 32'd1, 1'b1);
    issue(32'h12345678, 32'd0, 1'b0);
    issue(32'h00001234, 32'd1, 1'b0);

    // Start while busy with different operands must be ignored.
    issue(32'h0BADF00D, 32'hC0000001, 1'b1);
    repeat (5) @(negedge clock);
    bus.start = 1'b1; bus.a = 32'h00000003; bus.b = 32'h00000002; bus.sign = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;

    // Reset mid-run aborts without a done pulse.
    issue(32'hDEADBEEF, 32'h87654321, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    idle_at = cycle;
    @(negedge clock);
    reset = 1'b0;
    issue(32'd7, 32'd6, 1'b0);

    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      issue(x, y, s);
    end

    while (cycle <= idle_at + 3) @(negedge clock);
    check("drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Iterative 32x32 -> 64-bit shift-add multiplier for the multi-cycle CPU datapath.
- Serves MULT/MULTU and writes HI/LO. It is the multiplicative counterpart of the sequential divider.
- Uses the same start/busy handshake as the divider, so the control unit can stall on busy for both units identically.
- Each run takes 32 iteration cycles. The result is held stable until the next accepted start.

Parameters:
- N, 32, operand width; the product is 2N bits.
- CW, 5, iteration counter width; must equal clog2(N).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a  input  N  multiplicand; sampled only on an accepted start
- b  input  N  multiplier; sampled only on an accepted start
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled on an accepted start
- start  input  1  request; accepted only when busy=0
- hi  output  N  upper half of the product (registered)
- lo  output  N  lower half of the product (registered)
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when hi/lo update

Behaviour:
- Reset (async, active-high):
  - busy=0, done=0, hi=0, lo=0, count=0, internal accumulators=0.
  - Reset asserted mid-operation aborts the run; no done pulse is produced.
- Accept (edge where start=1 and busy=0):
  - If sign=1 and a[N-1]=1, latch |a| into reg_a; otherwise latch a. Apply the same rule to b into reg_b.
  - Latch neg = sign & (a[N-1] ^ b[N-1]).
  - Clear acc_hi (N+1 bits) and count; set busy=1.
  - |-2^31| = 0x80000000 is interpreted as an unsigned magnitude, so it is valid.
- Iterate (each edge while busy=1):
  - t = acc_hi + (reg_b[0] ? reg_a : 0), computed N+1 bits wide.
  - {acc_hi, reg_b} <= {1'b0, t, reg_b} >> 1. The low half accumulates in reg_b.
  - count <= count + 1.
- Finish (iteration edge where count == N-1):
  - busy<=0 and done<=1 on the same edge.
  - {hi, lo} <= neg ? -P : P, where P is the final 2N-bit value. Negation is two's-complement over 2N bits.
- Latency:
  - Start accepted at edge E; busy is high after E through E+32.
  - At edge E+32, busy falls, done=1 for one cycle, and hi/lo are valid.
- Back-to-back: start may be re-asserted in the same cycle that done=1, because busy=0 then. The new accept occurs at E+33.
- start while busy=1 is ignored; operands and sign are not re-sampled.
- hi/lo change only at Finish or reset. Inputs a, b and sign may change freely while busy.
- done is 0 in every cycle other than the Finish cycle.

Optional Feature:
- Macro: MULT_EARLY_OUT_EN.
- Defined:
  - Iteration also finishes when the remaining unprocessed multiplier bits are all zero. Unprocessed bits means reg_b[N-1-count:0] before the shift.
  - The remaining shift is applied in one step, so the product is identical to the full-length run.
  - Finish still raises done for one cycle and drops busy.
  - Operand b=0 finishes at E+1.
  - Latency is therefore data-dependent: 1..32 cycles.
- Undefined: fixed 32-cycle latency exactly as specified above.

Decomposition:
- Shared package: MUL_N=32, MUL_CW=5, and a mul_op_t enum {MUL_UNSIGNED, MUL_SIGNED}. The divider can reuse MUL_N.
- Sub-module: none needed for the core datapath.
- The operand conditional-negate (abs) may be one small shared function in the package, neg_if(x, c), also usable by the divider.

Test Plan:
- Unsigned, large operands: sign=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 32 busy cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- Signed, mixed signs: sign=1, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands with sign=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Signed corner: sign=1, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Then a=0x80000000, b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Handshake:
  - Start pulsed while busy, with a changed mid-run -> ignored; the result matches the operands latched at accept.
  - Back-to-back start asserted in the done cycle -> second result after exactly 33 more edges.
- Reset mid-run: assert reset at iteration 10 -> busy=0, hi=lo=0 immediately (asynchronous); no done pulse. A subsequent start of 7*6 gives lo=42, hi=0.
- MULT_EARLY_OUT_EN: b=0 -> done at E+1 with hi=lo=0; b=1, a=0x1234 -> lo=0x1234. Random signed/unsigned pairs must match the reference product with the macro both defined and undefined.
